// File: rtl/numbat_pkg.sv
// Shared widths, piece encodings, FSM state type and board-indexing helpers
// for the chess attack-map block.
package numbat_pkg;

    localparam int PIECE_WIDTH = 4;
    localparam int BOARD_WIDTH = 64 * PIECE_WIDTH;
    localparam int BLACK_BIT   = 3;

    localparam logic [2:0] PT_EMPTY  = 3'd0;
    localparam logic [2:0] PT_PAWN   = 3'd1;
    localparam logic [2:0] PT_KNIGHT = 3'd2;
    localparam logic [2:0] PT_BISHOP = 3'd3;
    localparam logic [2:0] PT_ROOK   = 3'd4;
    localparam logic [2:0] PT_QUEEN  = 3'd5;
    localparam logic [2:0] PT_KING   = 3'd6;
    localparam logic [2:0] PT_NONE   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int sq_row(input logic [5:0] sq);
        return int'(sq[5:3]);
    endfunction

    function automatic int sq_col(input logic [5:0] sq);
        return int'(sq[2:0]);
    endfunction

    function automatic logic [PIECE_WIDTH-1:0] piece_at(input logic [BOARD_WIDTH-1:0] b,
                                                        input logic [5:0] sq);
        return b[{sq, 2'b00} +: PIECE_WIDTH];
    endfunction

    // Codes 0 and 7 both mean an empty square, so ray blocking ignores them.
    function automatic logic piece_occupied(input logic [PIECE_WIDTH-1:0] p);
        return (p[2:0] != PT_EMPTY) && (p[2:0] != PT_NONE);
    endfunction

endpackage

// File: rtl/piece_attack_gen.sv
// Combinational attack mask for one piece on one square of a given board.
// Sliding pieces walk 8 directions x 7 steps and stop on the first occupied square.
module piece_attack_gen
    import numbat_pkg::*;
(
    input  logic [PIECE_WIDTH-1:0] piece,
    input  logic [5:0]             square,
    input  logic [BOARD_WIDTH-1:0] board,
    output logic [63:0]            attack
);

    function automatic logic [63:0] point(input int r, input int c);
        if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
            return 64'd1 << 6'(r * 8 + c);
        end else begin
            return 64'd0;
        end
    endfunction

    function automatic logic [63:0] ray(input logic [BOARD_WIDTH-1:0] b,
                                        input int r0, input int c0,
                                        input int dr, input int dc);
        logic [63:0] m;
        logic        blocked;
        int          r;
        int          c;
        m       = 64'd0;
        blocked = 1'b0;
        for (int k = 1; k < 8; k++) begin
            r = r0 + dr * k;
            c = c0 + dc * k;
            if (!blocked && r >= 0 && r < 8 && c >= 0 && c < 8) begin
                m = m | (64'd1 << 6'(r * 8 + c));
                blocked = piece_occupied(piece_at(b, 6'(r * 8 + c)));
            end else begin
                blocked = 1'b1;
            end
        end
        return m;
    endfunction

    int row;
    int col;
    int fwd;

    // Per-type attack pattern for the examined square.
    always_comb begin
        attack = 64'd0;
        row    = sq_row(square);
        col    = sq_col(square);
        fwd    = piece[BLACK_BIT] ? -1 : 1;
        case (piece[2:0])
            PT_PAWN: attack = point(row + fwd, col - 1) | point(row + fwd, col + 1);
            PT_KNIGHT: attack = point(row + 1, col + 2) | point(row + 2, col + 1)
                              | point(row + 2, col - 1) | point(row + 1, col - 2)
                              | point(row - 1, col - 2) | point(row - 2, col - 1)
                              | point(row - 2, col + 1) | point(row - 1, col + 2);
            PT_KING: attack = point(row + 1, col - 1) | point(row + 1, col) | point(row + 1, col + 1)
                            | point(row, col - 1)                          | point(row, col + 1)
                            | point(row - 1, col - 1) | point(row - 1, col) | point(row - 1, col + 1);
            PT_BISHOP: attack = ray(board, row, col, 1, 1) | ray(board, row, col, 1, -1)
                              | ray(board, row, col, -1, 1) | ray(board, row, col, -1, -1);
            PT_ROOK: attack = ray(board, row, col, 1, 0) | ray(board, row, col, -1, 0)
                            | ray(board, row, col, 0, 1) | ray(board, row, col, 0, -1);
            PT_QUEEN: attack = ray(board, row, col, 1, 1) | ray(board, row, col, 1, -1)
                             | ray(board, row, col, -1, 1) | ray(board, row, col, -1, -1)
                             | ray(board, row, col, 1, 0) | ray(board, row, col, -1, 0)
                             | ray(board, row, col, 0, 1) | ray(board, row, col, 0, -1);
            default: attack = 64'd0;
        endcase
    end

endmodule

// File: rtl/board_attack_map.sv
// Scans a latched chess board one square per clock, accumulating per-colour
// attack maps, then registers king check flags and holds the result until cleared.
module board_attack_map
    import numbat_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BOARD_WIDTH-1:0] board,
    input  logic                   board_valid,
    input  logic                   clear_attack,
    output logic                   is_attacking_done,
    output logic [63:0]            white_is_attacking,
    output logic [63:0]            black_is_attacking,
    output logic                   white_in_check,
    output logic                   black_in_check
);

    state_t                 state_r;
    state_t                 state_s;
    logic [5:0]             cnt_r;
    logic                   last_r;
    logic [BOARD_WIDTH-1:0] board_r;
    logic [PIECE_WIDTH-1:0] scan_piece_s;
    logic [63:0]            scan_mask_s;
    logic [63:0]            white_king_s;
    logic [63:0]            black_king_s;

    assign scan_piece_s = piece_at(board_r, cnt_r);

    piece_attack_gen u_gen (
        .piece  (scan_piece_s),
        .square (cnt_r),
        .board  (board_r),
        .attack (scan_mask_s)
    );

    // King locations on the latched board, for the check flags.
    always_comb begin
        white_king_s = 64'd0;
        black_king_s = 64'd0;
        for (int s = 0; s < 64; s++) begin
            white_king_s[s] = (piece_at(board_r, 6'(s)) == {1'b0, PT_KING});
            black_king_s[s] = (piece_at(board_r, 6'(s)) == {1'b1, PT_KING});
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; clear_attack dominates every state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_attack)     state_s = ST_IDLE;
                else if (board_valid) state_s = ST_SCAN;
                else                  state_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (clear_attack) state_s = ST_IDLE;
                else if (last_r)  state_s = ST_DONE;
                else              state_s = ST_SCAN;
            end
            ST_DONE: begin
                if (clear_attack) state_s = ST_IDLE;
                else              state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Capture, per-square accumulation, and check-flag registration.
    // last_r marks that square 63 has been folded in, so flags see the final maps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r              <= 6'd0;
            last_r             <= 1'b0;
            board_r            <= '0;
            is_attacking_done  <= 1'b0;
            white_is_attacking <= 64'd0;
            black_is_attacking <= 64'd0;
            white_in_check     <= 1'b0;
            black_in_check     <= 1'b0;
        end else if (clear_attack) begin
            cnt_r              <= 6'd0;
            last_r             <= 1'b0;
            is_attacking_done  <= 1'b0;
            white_is_attacking <= 64'd0;
            black_is_attacking <= 64'd0;
            white_in_check     <= 1'b0;
            black_in_check     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (board_valid) begin
                        board_r            <= board;
                        cnt_r              <= 6'd0;
                        last_r             <= 1'b0;
                        white_is_attacking <= 64'd0;
                        black_is_attacking <= 64'd0;
                    end
                end
                ST_SCAN: begin
                    if (!last_r) begin
                        if (scan_piece_s[BLACK_BIT]) begin
                            black_is_attacking <= black_is_attacking | scan_mask_s;
                        end else begin
                            white_is_attacking <= white_is_attacking | scan_mask_s;
                        end
                        cnt_r  <= cnt_r + 6'd1;
                        last_r <= (cnt_r == 6'd63);
                    end else begin
                        white_in_check    <= |(white_king_s & black_is_attacking);
                        black_in_check    <= |(black_king_s & white_is_attacking);
                        is_attacking_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    is_attacking_done <= 1'b1;
                end
                default: begin
                    is_attacking_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_attack_map.sv
// Directed bench: a geometric reference model of chess attacks plus latency/handshake
// tracking, compared against the DUT every clock, with literal pins on the model.
module tb_board_attack_map;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] board;
    logic         board_valid;
    logic         clear_attack;
    logic         is_attacking_done;
    logic [63:0]  white_is_attacking;
    logic [63:0]  black_is_attacking;
    logic         white_in_check;
    logic         black_in_check;

    int checks   = 0;
    int failures = 0;

    board_attack_map dut (
        .clk                (clk),
        .reset              (reset),
        .board              (board),
        .board_valid        (board_valid),
        .clear_attack       (clear_attack),
        .is_attacking_done  (is_attacking_done),
        .white_is_attacking (white_is_attacking),
        .black_is_attacking (black_is_attacking),
        .white_in_check     (white_in_check),
        .black_in_check     (black_in_check)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] pc(input logic [255:0] b, input int s);
        return 4'(b >> (s * 4));
    endfunction

    function automatic logic occ(input logic [3:0] p);
        return (p[2:0] != 3'd0) && (p[2:0] != 3'd7);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic attacks(input logic [255:0] b, input int src, input int dst);
        logic [3:0] p;
        int dr, dc, ad, ac, sr, sc, r, c, n;
        logic straight, diag, ok;
        p  = pc(b, src);
        sr = src / 8; sc = src % 8;
        dr = dst / 8 - sr; dc = dst % 8 - sc;
        ad = iabs(dr); ac = iabs(dc);
        if (src == dst) return 1'b0;
        case (p[2:0])
            3'd1: return (dr == (p[3] ? -1 : 1)) && (ac == 1);
            3'd2: return (ad == 1 && ac == 2) || (ad == 2 && ac == 1);
            3'd6: return (ad <= 1) && (ac <= 1);
            3'd3, 3'd4, 3'd5: begin
                straight = (dr == 0) || (dc == 0);
                diag     = (ad == ac);
                ok = (p[2:0] == 3'd3) ? diag : (p[2:0] == 3'd4) ? straight : (diag || straight);
                if (!ok) return 1'b0;
                n = (ad > ac) ? ad : ac;
                for (int k = 1; k < n; k++) begin
                    r = sr + (dr > 0 ? k : dr < 0 ? -k : 0);
                    c = sc + (dc > 0 ? k : dc < 0 ? -k : 0);
                    if (occ(pc(b, r * 8 + c))) return 1'b0;
                end
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] model_map(input logic [255:0] b, input logic black);
        logic [63:0] m;
        m = 64'd0;
        for (int s = 0; s < 64; s++)
            if (occ(pc(b, s)) && pc(b, s) >> 3 == {3'd0, black})
                for (int d = 0; d < 64; d++)
                    if (attacks(b, s, d)) m[d] = 1'b1;
        return m;
    endfunction

    // Is the king of colour 'black' standing on a square the other side attacks?
    function automatic logic model_check(input logic [255:0] b, input logic black);
        logic [63:0] opp;
        logic        hit;
        opp = model_map(b, ~black);
        hit = 1'b0;
        for (int s = 0; s < 64; s++)
            if (pc(b, s) == {black, 3'd6} && opp[s]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [255:0] put(input logic [255:0] b, input int s, input logic [3:0] p);
        logic [255:0] r;
        r = b;
        r[s * 4 +: 4] = p;
        return r;
    endfunction

    // phase: 0 idle, 1 scanning, 2 result valid; done expected 65 clocks after capture.
    int          m_phase;
    int          m_cnt;
    logic [63:0] exp_w, exp_b;
    logic        exp_wc, exp_bc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_cnt   <= 0;
        end else if (clear_attack) begin
            m_phase <= 0;
        end else if (m_phase == 0 && board_valid) begin
            m_phase <= 1;
            m_cnt   <= 0;
            exp_w   <= model_map(board, 1'b0);
            exp_b   <= model_map(board, 1'b1);
            exp_wc  <= model_check(board, 1'b0);
            exp_bc  <= model_check(board, 1'b1);
        end else if (m_phase == 1) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 64) m_phase <= 2;
        end
    end

    // ---------------- checking ----------------
    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic compare_cycle();
        if (reset === 1'b1) begin
            check64("done", {63'd0, is_attacking_done}, {63'd0, m_phase == 2});
            if (m_phase == 2) begin
                check64("white_map", white_is_attacking, exp_w);
                check64("black_map", black_is_attacking, exp_b);
                check64("white_check", {63'd0, white_in_check}, {63'd0, exp_wc});
                check64("black_check", {63'd0, black_in_check}, {63'd0, exp_bc});
            end else if (m_phase == 0) begin
                check64("idle_maps", white_is_attacking | black_is_attacking, 64'd0);
                check64("idle_flags", {62'd0, white_in_check, black_in_check}, 64'd0);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
    endtask

    // Presents a board, scrambles the input after capture, and waits for done.
    task automatic run_board(input logic [255:0] b);
        int cnt;
        board       = b;
        board_valid = 1'b1;
        tick();
        cnt         = 1;
        board_valid = 1'b0;
        board       = ~b;
        while (is_attacking_done !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check64("latency", 64'(cnt - 1), 64'd65);
    endtask

    task automatic clear_result();
        clear_attack = 1'b1;
        tick();
        clear_attack = 1'b0;
        tick();
    endtask

    logic [255:0] b;
    int           cnt;

    initial begin
        reset = 1'b0; board = '0; board_valid = 1'b0; clear_attack = 1'b0;
        repeat (3) tick();
        check64("reset_outputs", white_is_attacking | black_is_attacking, 64'd0);
        check64("reset_done", {61'd0, is_attacking_done, white_in_check, black_in_check}, 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Empty board.
        run_board('0);
        check64("empty_white", white_is_attacking, 64'd0);
        check64("empty_black", black_is_attacking, 64'd0);
        clear_result();

        // White rook a1.
        b = put('0, 0, 4'd4);
        check64("model_rook", model_map(b, 1'b0), 64'h01010101010101FE);
        run_board(b);
        check64("rook_white", white_is_attacking, 64'h01010101010101FE);
        check64("rook_black", black_is_attacking, 64'd0);
        clear_result();

        // Pawn on the h-file must not wrap.
        b = put('0, 15, 4'd1);
        check64("model_pawn", model_map(b, 1'b0), 64'h0000000000400000);
        run_board(b);
        check64("pawn_white", white_is_attacking, 64'h0000000000400000);
        clear_result();

        // Knight in the corner.
        b = put('0, 0, 4'd2);
        check64("model_knight", model_map(b, 1'b0), 64'h0000000000020400);
        run_board(b);
        check64("knight_white", white_is_attacking, 64'h0000000000020400);
        clear_result();

        // King e1 vs rook e8, then blocked by pawn e2.
        b = put(put('0, 4, 4'd6), 60, 4'd12);
        check64("model_check_open", {63'd0, model_check(b, 1'b0)}, 64'd1);
        run_board(b);
        check64("check_open_w", {63'd0, white_in_check}, 64'd1);
        check64("check_open_b", {63'd0, black_in_check}, 64'd0);
        clear_result();
        b = put(b, 12, 4'd1);
        check64("model_check_blocked", {63'd0, model_check(b, 1'b0)}, 64'd0);
        run_board(b);
        check64("check_blocked_w", {63'd0, white_in_check}, 64'd0);
        clear_result();

        // Mixed position: both kings in check.
        b = put('0, 3, 4'd5);
        b = put(b, 59, 4'd14);
        b = put(b, 6, 4'd2);
        b = put(b, 52, 4'd9);
        b = put(b, 58, 4'd11);
        b = put(b, 4, 4'd6);
        b = put(b, 21, 4'd10);
        run_board(b);
        check64("mixed_flags", {62'd0, white_in_check, black_in_check}, 64'd3);
        clear_result();

        // Clear mid-scan aborts.
        board = put('0, 0, 4'd4); board_valid = 1'b1;
        tick();
        board_valid = 1'b0;
        repeat (20) tick();
        clear_attack = 1'b1;
        tick();
        clear_attack = 1'b0;
        repeat (80) tick();
        check64("abort_done", {63'd0, is_attacking_done}, 64'd0);
        check64("abort_maps", white_is_attacking | black_is_attacking, 64'd0);

        // clear with valid held, then release: fresh capture next cycle.
        board = put('0, 0, 4'd2); board_valid = 1'b1; clear_attack = 1'b1;
        repeat (2) tick();
        clear_attack = 1'b0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (is_attacking_done !== 1'b1 && cnt < 200);
        check64("handshake_latency", 64'(cnt - 1), 64'd65);
        check64("handshake_map", white_is_attacking, 64'h0000000000020400);
        board_valid = 1'b0;
        clear_result();

        // Async reset mid-scan.
        board = put('0, 0, 4'd4); board_valid = 1'b1;
        tick();
        board_valid = 1'b0;
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        check64("async_reset_maps", white_is_attacking | black_is_attacking, 64'd0);
        check64("async_reset_done", {63'd0, is_attacking_done}, 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (70) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
